secuenciador_fetch: RTL and testbench

Instruction-fetch sequencer for the MicroUAZ8 core. Owns the program counter, drives the address of the 256×9 asynchronous-read program ROM, and captures each returned word into an instruction register. Presents that register to decode through a valid/ready handshake. Applies jump, call and return redirects and halt requests from decode, keeping return addresses in a small hardware stack.

---
 rtl/microuaz8_pkg.sv | 18 +
 rtl/secuenciador_fetch_if.sv | 60 ++++++
 rtl/pila_retorno.sv | 57 +++++
 rtl/secuenciador_fetch.sv | 133 +++++++++++++
 tb/tb_secuenciador_fetch.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/microuaz8_pkg.sv
// Shared MicroUAZ8 definitions: default widths, stack depth and fetch state encoding.
package microuaz8_pkg;

  localparam int unsigned AW_DEF     = 8;
  localparam int unsigned DW_DEF     = 9;
  localparam int unsigned SDEPTH_DEF = 4;

  typedef enum logic [0:0] {
    FETCH    = 1'b0,
    DETENIDO = 1'b1
  } estado_e;

  // Sequential successor of a program address, wrapping at 2^AW.
  function automatic logic [AW_DEF-1:0] pc_next(input logic [AW_DEF-1:0] pc);
    return AW_DEF'(pc + AW_DEF'(1));
  endfunction

endpackage

// File: rtl/secuenciador_fetch_if.sv
// Fetch-side bus: ROM port, instruction handshake to decode, and redirect/halt requests.
interface secuenciador_fetch_if
  import microuaz8_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);

  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          jmp_req;
  logic [AW-1:0] jmp_addr;
  logic          call_req;
  logic [AW-1:0] call_addr;
  logic          ret_req;
  logic          halt_req;
  logic          halted;
  logic          stack_err;

  // Sequencer side
  modport master (
    output rom_addr,
    input  rom_data,
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready,
    input  jmp_req,
    input  jmp_addr,
    input  call_req,
    input  call_addr,
    input  ret_req,
    input  halt_req,
    output halted,
    output stack_err
  );

  // ROM + decode side
  modport slave (
    input  rom_addr,
    output rom_data,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready,
    output jmp_req,
    output jmp_addr,
    output call_req,
    output call_addr,
    output ret_req,
    output halt_req,
    input  halted,
    input  stack_err
  );

endinterface

// File: rtl/pila_retorno.sv
// Return-address LIFO: pointer counts stored entries; dout shows the top entry.
module pila_retorno
  import microuaz8_pkg::*;
#(
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned SDEPTH = SDEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = $clog2(SDEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] mem_q [SDEPTH];
  logic [CW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] wr_idx_c, rd_idx_c;

  assign full     = (ptr_q == CW'(SDEPTH));
  assign empty    = (ptr_q == '0);
  assign wr_idx_c = ptr_q[PW-1:0];
  assign rd_idx_c = PW'(ptr_q - CW'(1));
  assign dout     = mem_q[rd_idx_c];

  // Pointer update; push on full and pop on empty are ignored.
  always_comb begin
    ptr_d = ptr_q;
    if (push && !full) begin
      ptr_d = ptr_q + CW'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - CW'(1);
    end
  end

  // Pointer register, empty on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage write; contents need no reset since the pointer gates visibility.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_idx_c] <= din;
    end
  end

endmodule

// File: rtl/secuenciador_fetch.sv
// Instruction-fetch sequencer: owns pc, loads the instruction register from ROM,
// and applies halt/ret/call/jmp redirects on an accepted handshake.
module secuenciador_fetch
  import microuaz8_pkg::*;
#(
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned SDEPTH = SDEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  secuenciador_fetch_if.master fetch_if
);

  estado_e       state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [AW-1:0] instr_pc_q, instr_pc_d;
  logic          valid_q, valid_d;
  logic          halted_q, halted_d;
  logic          err_q, err_d;

  logic          hs_c;
  logic          load_c;
  logic          push_c;
  logic          pop_c;
  logic [AW-1:0] stk_dout_c;
  logic          stk_full_c;
  logic          stk_empty_c;

  pila_retorno #(
    .AW     (AW),
    .SDEPTH (SDEPTH)
  ) u_pila (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .din   (AW'(instr_pc_q + AW'(1))),
    .dout  (stk_dout_c),
    .full  (stk_full_c),
    .empty (stk_empty_c)
  );

  assign fetch_if.rom_addr    = pc_q;
  assign fetch_if.instr       = instr_q;
  assign fetch_if.instr_pc    = instr_pc_q;
  assign fetch_if.instr_valid = valid_q;
  assign fetch_if.halted      = halted_q;
  assign fetch_if.stack_err   = err_q;

  assign hs_c = valid_q & fetch_if.instr_ready;

  // Next-state: requests only matter on a handshake, priority halt > ret > call > jmp.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    err_d      = err_q;
    load_c     = 1'b0;
    push_c     = 1'b0;
    pop_c      = 1'b0;

    case (state_q)
      FETCH: begin
        if (hs_c && fetch_if.halt_req) begin
          state_d  = DETENIDO;
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end else if (hs_c && fetch_if.ret_req && !stk_empty_c) begin
          pop_c   = 1'b1;
          pc_d    = stk_dout_c;
          valid_d = 1'b0;
        end else if (hs_c && fetch_if.ret_req) begin
          // Underflow: flag it and keep fetching sequentially.
          err_d  = 1'b1;
          load_c = 1'b1;
        end else if (hs_c && fetch_if.call_req) begin
          if (stk_full_c) begin
            err_d = 1'b1;
          end else begin
            push_c = 1'b1;
          end
          pc_d    = fetch_if.call_addr;
          valid_d = 1'b0;
        end else if (hs_c && fetch_if.jmp_req) begin
          pc_d    = fetch_if.jmp_addr;
          valid_d = 1'b0;
        end else if (!valid_q || fetch_if.instr_ready) begin
          load_c = 1'b1;
        end

        if (load_c) begin
          instr_d    = fetch_if.rom_data;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = AW'(pc_q + AW'(1));
        end
      end
      DETENIDO: begin
        // Frozen until reset.
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_secuenciador_fetch.sv
// Directed bench for secuenciador_fetch with a ROM holding mem[i]=i and an
// expected-instr_pc scoreboard popped on every accepted handshake.
module tb_secuenciador_fetch;
  import microuaz8_pkg::*;

  localparam int unsigned AW     = 8;
  localparam int unsigned DW     = 9;
  localparam int unsigned SDEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  secuenciador_fetch_if #(.AW(AW), .DW(DW)) ifc ();

  secuenciador_fetch #(.AW(AW), .DW(DW), .SDEPTH(SDEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_if (ifc.master)
  );

  logic [DW-1:0] rom [256];
  assign ifc.rom_data = rom[ifc.rom_addr];

  int            tests_run    = 0;
  int            tests_failed = 0;
  logic [AW-1:0] sb_q [$];
  logic [AW-1:0] ret_stk [$];
  logic [AW-1:0] m_pc;
  logic [AW-1:0] ret_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the instruction being consumed (if any), then advance one clock.
  task automatic tick();
    logic [AW-1:0] e;
    if (ifc.instr_valid === 1'b1 && ifc.instr_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk("instr_pc", 32'(ifc.instr_pc), 32'(e));
        chk("instr", 32'(ifc.instr), 32'(DW'(e)));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    ifc.jmp_req   = 1'b0;
    ifc.jmp_addr  = '0;
    ifc.call_req  = 1'b0;
    ifc.call_addr = '0;
    ifc.ret_req   = 1'b0;
    ifc.halt_req  = 1'b0;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    ifc.instr_ready = 1'b0;
    clear_req();
    sb_q.delete();
    ret_stk.delete();
    tick();
    rst = 1'b0;
    tick();
    m_pc = '0;
  endtask

  // Consume n sequential instructions with ready held high.
  task automatic adv(input int n);
    ifc.instr_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(m_pc);
      m_pc = AW'(m_pc + AW'(1));
      tick();
    end
  endtask

  // Redirect request already driven: accept it, check the bubble, then the reload.
  task automatic redir(input logic [AW-1:0] target, input string tag);
    ifc.instr_ready = 1'b1;
    sb_q.push_back(m_pc);
    tick();
    clear_req();
    chk({tag, "_bubble_valid"}, 32'(ifc.instr_valid), 32'd0);
    chk({tag, "_rom_addr"}, 32'(ifc.rom_addr), 32'(target));
    tick();
    m_pc = target;
    chk({tag, "_reload_valid"}, 32'(ifc.instr_valid), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = DW'(i);

    // Reset values
    rst             = 1'b1;
    ifc.instr_ready = 1'b0;
    clear_req();
    tick();
    tick();
    chk("rst_instr", 32'(ifc.instr), 32'd0);
    chk("rst_instr_pc", 32'(ifc.instr_pc), 32'd0);
    chk("rst_valid", 32'(ifc.instr_valid), 32'd0);
    chk("rst_rom_addr", 32'(ifc.rom_addr), 32'd0);
    chk("rst_halted", 32'(ifc.halted), 32'd0);
    chk("rst_stack_err", 32'(ifc.stack_err), 32'd0);

    // First edge out of reset loads mem[0]
    rst = 1'b0;
    tick();
    m_pc = '0;
    chk("first_valid", 32'(ifc.instr_valid), 32'd1);
    chk("first_instr", 32'(ifc.instr), 32'd0);

    // Sequential stream through the 255 -> 0 wrap
    adv(260);
    chk("wrap_instr_pc", 32'(ifc.instr_pc), 32'd4);

    // Stall at instr_pc=5 with a jump request that must be ignored
    do_reset();
    adv(5);
    ifc.instr_ready = 1'b0;
    ifc.jmp_req     = 1'b1;
    ifc.jmp_addr    = 8'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr_pc", 32'(ifc.instr_pc), 32'd5);
      chk("stall_instr", 32'(ifc.instr), 32'd5);
      chk("stall_rom_addr", 32'(ifc.rom_addr), 32'd6);
      chk("stall_valid", 32'(ifc.instr_valid), 32'd1);
    end
    clear_req();
    adv(3);

    // Jump to 0x40 on the handshake of instr_pc=3
    do_reset();
    adv(3);
    ifc.jmp_req  = 1'b1;
    ifc.jmp_addr = 8'h40;
    redir(8'h40, "jmp");
    adv(3);

    // Call 0x80 at 0x10, return at 0x82 to 0x11
    do_reset();
    adv(16);
    ifc.call_req  = 1'b1;
    ifc.call_addr = 8'h80;
    redir(8'h80, "call");
    chk("call_stack_err", 32'(ifc.stack_err), 32'd0);
    adv(2);
    ifc.ret_req = 1'b1;
    redir(8'h11, "ret");
    adv(2);

    // Five nested calls overflow a four-deep stack; four returns unwind in LIFO order
    do_reset();
    adv(2);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) ret_stk.push_back(AW'(m_pc + AW'(1)));
      ifc.call_req  = 1'b1;
      ifc.call_addr = AW'(8'h20 * (k + 1));
      redir(AW'(8'h20 * (k + 1)), "nest_call");
      chk("nest_stack_err", 32'(ifc.stack_err), (k == 4) ? 32'd1 : 32'd0);
      adv(1);
    end
    for (int k = 0; k < 4; k++) begin
      ret_t       = ret_stk.pop_back();
      ifc.ret_req = 1'b1;
      redir(ret_t, "nest_ret");
      adv(1);
    end
    chk("nest_err_sticky", 32'(ifc.stack_err), 32'd1);

    // Return on an empty stack at instr_pc=7: error, sequential load
    do_reset();
    adv(7);
    ifc.ret_req = 1'b1;
    sb_q.push_back(m_pc);
    tick();
    clear_req();
    m_pc = AW'(m_pc + AW'(1));
    chk("empty_ret_err", 32'(ifc.stack_err), 32'd1);
    chk("empty_ret_valid", 32'(ifc.instr_valid), 32'd1);
    adv(2);

    // Halt wins over a simultaneous jump; only reset leaves DETENIDO
    do_reset();
    adv(4);
    ifc.halt_req = 1'b1;
    ifc.jmp_req  = 1'b1;
    ifc.jmp_addr = 8'h40;
    sb_q.push_back(m_pc);
    tick();
    chk("halt_halted", 32'(ifc.halted), 32'd1);
    chk("halt_valid", 32'(ifc.instr_valid), 32'd0);
    chk("halt_rom_addr", 32'(ifc.rom_addr), 32'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halted_rom_addr", 32'(ifc.rom_addr), 32'd5);
      chk("halted_valid", 32'(ifc.instr_valid), 32'd0);
      chk("halted_flag", 32'(ifc.halted), 32'd1);
    end
    clear_req();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("post_halt_instr_pc", 32'(ifc.instr_pc), 32'd0);
    chk("post_halt_valid", 32'(ifc.instr_valid), 32'd1);
    chk("post_halt_halted", 32'(ifc.halted), 32'd0);
    chk("post_halt_stack_err", 32'(ifc.stack_err), 32'd0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
